disp_scan_ctrl: RTL
===================

// Module: disp_scan_ctrl
// PURPOSE
//  Time-multiplexing scheduler for a 4-digit common-anode 7-seg display driven through one
//  shared hex-to-7seg decoder. Holds a double-buffered 16-bit hex value with point/blank masks.
//  Cycles one digit at a time and presents that digit's nibble, point and LE to the decoder.
//  Drives the active-low anode for that digit, with a guard gap against ghosting.
//  New data is committed only at a frame boundary, so a frame never mixes old and new values.
// PARAMETERS
//  DIV_W   17  width of refresh divider; one digit slot = 2**DIV_W clk cycles
//  GUARD   16  cycles at slot start with all anodes off (must be < 2**DIV_W)
//  LZB_EN  1   1 = leading-zero blanking enabled, 0 = disabled
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  load         in   1   1-cycle strobe: capture hex_in/pt_in/blank_in into pending buffer
//  hex_in       in   16  digit i = hex_in[4i+3:4i], digit 0 rightmost
//  pt_in        in   4   decimal point per digit, 1 = lit
//  blank_in     in   4   forced blank per digit, 1 = dark
//  an           out  4   anode enables, active-low, an[i] = digit i
//  dig          out  4   nibble to decoder {D3,D2,D1,D0}
//  le           out  1   decoder LE, 1 = segments a..g off
//  point        out  1   decoder point input for current digit
//  pend         out  1   1 = pending data not yet committed
//  frame_start  out  1   1-cycle pulse on commit tick (last cycle of digit 3 slot)
// BEHAVIOUR
//  Reset (async, immediate): div_cnt=0, sel=0, active hex=0, active pt=0, active blank=4'hF.
//   Also: pend=0, pending regs=0. Outputs: an=4'hF, dig=0, le=1, point=0, pend=0, frame_start=0.
//  Divider: div_cnt (DIV_W bits) increments every clk and wraps to 0.
//   tick = (div_cnt == all ones).
//  Slot pointer: on tick, sel advances 0->1->2->3->0 (2-bit wrap).
//  Commit tick = tick && sel==3. On a commit tick, if pend, active <= pending and pend <= 0.
//  load when not a commit tick: pending <= inputs, pend <= 1.
//   A second load before commit overwrites pending (last wins).
//  load on a commit tick: active <= inputs directly (bypass), pend <= 0. Older pending is dropped.
//  frame_start = commit tick, registered-free decode of div_cnt/sel (asserted regardless of pend).
//  Output decode, combinational from registers only (no input-to-output path):
//   dig   = active_hex[4*sel+3 : 4*sel]
//   point = active_pt[sel]
//   le    = active_blank[sel] | lzb[sel]
//   an    = 4'hF when div_cnt < GUARD, else ~(4'b0001 << sel)
//  Leading-zero blanking (LZB_EN=1): lzb[i]=1 if i>0 and digits i..3 are all 4'h0.
//   Digit 0 is never LZB-blanked. LZB_EN=0 forces lzb=0.
//   LZB does not affect point; blank_in does not affect point.
//  Active data changes only at the commit tick, so it takes effect from slot sel=0.
//  Worst-case latency from load to display: 4*2**DIV_W cycles.
//  Reset mid-frame discards pending and active data; after release, scanning restarts at sel=0.
// TESTING  (use DIV_W=4, GUARD=2: slot = 16 cycles)
//  1 Mid-scan async rst=1 without clk edge -> an=4'hF, le=1, pend=0 immediately.
//    After release, sel=0 and div_cnt=0.
//  2 load hex=16'h1234, pt=4'b0010, blank=0 -> pend=1 until commit tick, frame_start pulses.
//    Next frame shows dig 4,3,2,1 with an 1110,1101,1011,0111.
//    an=4'hF on cycles 0-1 of each slot; point=1 only in slot 1.
//  3 LZB: hex=16'h0050 -> le=1 in slots 3,2; dig 5 shown in slot 1; 0 shown in slot 0.
//    hex=16'h0000 -> only slot 0 lit.
//    Repeat with LZB_EN=0 -> all four slots lit.
//  4 load 16'hAAAA at slot 1, then load 16'hBBBB at slot 2 -> next frame shows all B.
//    AAAA is never displayed; pend falls on the commit tick.
//  5 load 16'hCCCC exactly on commit tick while pend=1 holds 16'hDDDD -> next frame is all C.
//    pend=0 the following cycle.
//  6 blank_in=4'b0101, pt_in=4'hF -> le=1 in slots 0,2 while point=1 in all slots.
//    Run 3 frames to check the sel and div_cnt wrap.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit multiplexed 7-seg scan scheduler with frame-aligned double buffer
module disp_scan_ctrl #(
    parameter int DIV_W  = 17,
    parameter int GUARD  = 16,
    parameter bit LZB_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] hex_in,
    input  logic [3:0]  pt_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  an,
    output logic [3:0]  dig,
    output logic        le,
    output logic        point,
    output logic        pend,
    output logic        frame_start
);

    localparam logic [DIV_W-1:0] GUARD_C = DIV_W'(GUARD);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [15:0]      act_hex_q, act_hex_d;
    logic [3:0]       act_pt_q, act_pt_d;
    logic [3:0]       act_blank_q, act_blank_d;
    logic [15:0]      pnd_hex_q, pnd_hex_d;
    logic [3:0]       pnd_pt_q, pnd_pt_d;
    logic [3:0]       pnd_blank_q, pnd_blank_d;
    logic             pend_q, pend_d;
    logic             tick, commit;
    logic [3:0]       lzb;

    assign tick   = &div_cnt_q;
    assign commit = tick && (sel_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            sel_q       <= 2'd0;
            act_hex_q   <= 16'h0;
            act_pt_q    <= 4'h0;
            act_blank_q <= 4'hF;
            pnd_hex_q   <= 16'h0;
            pnd_pt_q    <= 4'h0;
            pnd_blank_q <= 4'h0;
            pend_q      <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            sel_q       <= sel_d;
            act_hex_q   <= act_hex_d;
            act_pt_q    <= act_pt_d;
            act_blank_q <= act_blank_d;
            pnd_hex_q   <= pnd_hex_d;
            pnd_pt_q    <= pnd_pt_d;
            pnd_blank_q <= pnd_blank_d;
            pend_q      <= pend_d;
        end
    end

    always_comb begin
        div_cnt_d   = div_cnt_q + DIV_W'(1);
        sel_d       = tick ? sel_q + 2'd1 : sel_q;
        act_hex_d   = act_hex_q;
        act_pt_d    = act_pt_q;
        act_blank_d = act_blank_q;
        pnd_hex_d   = pnd_hex_q;
        pnd_pt_d    = pnd_pt_q;
        pnd_blank_d = pnd_blank_q;
        pend_d      = pend_q;
        if (load && commit) begin
            // Load landing on the frame boundary goes straight to the display; stale pending is dropped.
            act_hex_d   = hex_in;
            act_pt_d    = pt_in;
            act_blank_d = blank_in;
            pend_d      = 1'b0;
        end else if (load) begin
            pnd_hex_d   = hex_in;
            pnd_pt_d    = pt_in;
            pnd_blank_d = blank_in;
            pend_d      = 1'b1;
        end else if (commit && pend_q) begin
            act_hex_d   = pnd_hex_q;
            act_pt_d    = pnd_pt_q;
            act_blank_d = pnd_blank_q;
            pend_d      = 1'b0;
        end
    end

    // A digit is leading-zero blanked when it and every digit to its left are zero.
    always_comb begin
        lzb = 4'h0;
        if (LZB_EN) begin
            lzb[3] = (act_hex_q[15:12] == 4'h0);
            lzb[2] = (act_hex_q[15:8]  == 8'h0);
            lzb[1] = (act_hex_q[15:4]  == 12'h0);
        end
    end

    assign dig         = act_hex_q[4*sel_q +: 4];
    assign point       = act_pt_q[sel_q];
    assign le          = act_blank_q[sel_q] | lzb[sel_q];
    assign an          = (div_cnt_q < GUARD_C) ? 4'hF : ~(4'b0001 << sel_q);
    assign pend        = pend_q;
    assign frame_start = commit;

endmodule
